// File: rtl/ubti_pkg.sv
// Shared types and constants for the uBlock two-share S-layer feeder.
package ubti_pkg;

  localparam int unsigned STATE_W          = 64;
  localparam int unsigned NIBBLES          = 16;
  localparam int unsigned SBOX_LAT_DEFAULT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Unmasked uBlock 4-bit S-box, indexed by input nibble
  localparam logic [3:0] SBOX_TABLE [16] = '{
    4'h7, 4'h4, 4'h9, 4'hC, 4'hB, 4'hA, 4'hD, 4'h8,
    4'hF, 4'hE, 4'h1, 4'h6, 4'h0, 4'h3, 4'h2, 4'h5
  };

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX_TABLE[x];
  endfunction

endpackage

// File: rtl/shared_s_box_array.sv
// Two-share S-layer over 16 nibbles; output shares are re-split with guard
// nibbles taken from neighbouring share-0 nibbles, then delayed LAT registers.
module shared_s_box_array
  import ubti_pkg::*;
#(
  parameter int unsigned LAT = SBOX_LAT_DEFAULT
) (
  input  logic               clk,
  input  logic [STATE_W-1:0] sin0,
  input  logic [STATE_W-1:0] sin1,
  output logic [STATE_W-1:0] sout0,
  output logic [STATE_W-1:0] sout1
);

  logic [STATE_W-1:0] guard;
  logic [STATE_W-1:0] masked;
  logic [LAT-1:0][STATE_W-1:0] pipe0;
  logic [LAT-1:0][STATE_W-1:0] pipe1;

  always_comb begin
    guard = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      guard[4*i +: 4] = sin0[4*((i + 1) % NIBBLES) +: 4]
                      ^ sin0[4*((i + NIBBLES - 1) % NIBBLES) +: 4];
    end
  end

  always_comb begin
    masked = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      masked[4*i +: 4] = sbox4(sin0[4*i +: 4] ^ sin1[4*i +: 4]) ^ guard[4*i +: 4];
    end
  end

  // Pipeline is intentionally unreset; the feeder never captures stale data
  if (LAT == 1) begin : g_single
    always_ff @(posedge clk) begin
      pipe0 <= guard;
      pipe1 <= masked;
    end
  end else begin : g_deep
    always_ff @(posedge clk) begin
      pipe0 <= {pipe0[LAT-2:0], guard};
      pipe1 <= {pipe1[LAT-2:0], masked};
    end
  end

  assign sout0 = pipe0[LAT-1];
  assign sout1 = pipe1[LAT-1];

endmodule

// File: rtl/ubti_sbox_round_feeder.sv
// Handshake front end for the two-share S-layer: key addition into a stable
// input register, fixed-latency wait, then held output presentation.
module ubti_sbox_round_feeder
  import ubti_pkg::*;
#(
  parameter int unsigned SBOX_LAT = SBOX_LAT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_share0,
  input  logic [STATE_W-1:0] in_share1,
  input  logic [STATE_W-1:0] rk_share0,
  input  logic [STATE_W-1:0] rk_share1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_share0,
  output logic [STATE_W-1:0] out_share1
);

  localparam int unsigned         CNT_W   = 3;
  localparam logic [CNT_W-1:0]    LAT_CNT = CNT_W'(SBOX_LAT);

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic               capture;
  logic [CNT_W-1:0]   cnt;
  logic [STATE_W-1:0] sin0;
  logic [STATE_W-1:0] sin1;
  logic [STATE_W-1:0] sout0;
  logic [STATE_W-1:0] sout1;

  shared_s_box_array #(
    .LAT (SBOX_LAT)
  ) u_sbox (
    .clk   (clk),
    .sin0  (sin0),
    .sin1  (sin1),
    .sout0 (sout0),
    .sout1 (sout1)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == LAT_CNT) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Shares stay in separate registers; sin* move only on accept or reset
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      sin0       <= '0;
      sin1       <= '0;
      cnt        <= '0;
      out_share0 <= '0;
      out_share1 <= '0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      if (accept) begin
        sin0 <= in_share0 ^ rk_share0;
        sin1 <= in_share1 ^ rk_share1;
        cnt  <= '0;
      end else if ((state == WAIT) && !capture) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (capture) begin
        out_share0 <= sout0;
        out_share1 <= sout1;
      end
    end
  end

endmodule
